// File: rtl/laser_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : laser_pkg
//  Purpose  : Shared constants, FSM state encoding and grid position type for
//             the two-circle laser coverage scan scheduler.
//  Revision : 1.0  initial release
// ============================================================================
package laser_pkg;

    // Coordinate width; the candidate grid is 2^CW x 2^CW.
    localparam int CW         = 4;
    // Coverage count width.
    localparam int NW         = 6;
    // Pass limit for the alternating optimisation.
    localparam int MAX_ITER   = 6;
    // Evaluator request window.
    localparam int MAX_OUT    = 4;
    // Grid geometry.
    localparam int GRID_DIM   = 1 << CW;
    localparam int GRID_CELLS = GRID_DIM * GRID_DIM;

    // Scheduler states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SWEEP  = 3'd1,
        DRAIN  = 3'd2,
        SWAP   = 3'd3,
        FINISH = 3'd4
    } state_t;

    // Grid position; the packing {y,x} matches the row-major scan index.
    typedef struct packed {
        logic [CW-1:0] y;
        logic [CW-1:0] x;
    } pos_t;

endpackage
`default_nettype wire

// File: rtl/laser_cand_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : laser_cand_fifo
//  Purpose  : Small in-order FIFO of candidate positions awaiting an evaluator
//             response. Push and pop may coincide, also when full or empty.
//  Revision : 1.0  initial release
// ============================================================================
module laser_cand_fifo
    import laser_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         i_push,
    input  pos_t                         i_din,
    input  logic                         i_pop,
    output pos_t                         o_dout,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_full,
    output logic                         o_empty
);

    localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = $clog2(DEPTH+1);

    pos_t             r_mem [DEPTH];
    logic [c_PW-1:0]  r_wr;
    logic [c_PW-1:0]  r_rd;
    logic [c_CW-1:0]  r_count;

    logic             w_do_pop;
    logic             w_do_push;
    logic [c_PW-1:0]  w_wr_nxt;
    logic [c_PW-1:0]  w_rd_nxt;

    // A pop on an empty FIFO is dropped; a push on a full FIFO lands only if a pop frees a slot.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign w_wr_nxt  = (r_wr == c_PW'(DEPTH-1)) ? '0 : r_wr + 1'b1;
    assign w_rd_nxt  = (r_rd == c_PW'(DEPTH-1)) ? '0 : r_rd + 1'b1;

    assign o_dout  = r_mem[r_rd];
    assign o_count = r_count;
    assign o_full  = (r_count == c_CW'(DEPTH));
    assign o_empty = (r_count == '0);

    // Storage write; contents need no reset since the count gates every read.
    always_ff @(posedge CLK) begin
        if (w_do_push) begin
            r_mem[r_wr] <= i_din;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wr <= w_wr_nxt;
            if (w_do_pop)  r_rd <= w_rd_nxt;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/laser_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : laser_scan_ctrl
//  Purpose  : Scan scheduler for the two-circle coverage search. Sweeps every
//             grid candidate through a pipelined evaluator, alternating the
//             optimised circle per pass until convergence or the pass limit.
//  Revision : 1.0  initial release
// ============================================================================
module laser_scan_ctrl #(
    parameter int CW       = laser_pkg::CW,
    parameter int NW       = laser_pkg::NW,
    parameter int MAX_ITER = laser_pkg::MAX_ITER,
    parameter int MAX_OUT  = laser_pkg::MAX_OUT
)(
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] C1X,
    output logic [CW-1:0] C1Y,
    output logic [CW-1:0] C2X,
    output logic [CW-1:0] C2Y,
    output logic          err,
    output logic          ev_req_valid,
    input  logic          ev_req_ready,
    output logic [CW-1:0] ev_cx,
    output logic [CW-1:0] ev_cy,
    output logic [CW-1:0] ev_fx,
    output logic [CW-1:0] ev_fy,
    input  logic          ev_rsp_valid,
    input  logic [NW-1:0] ev_rsp_cnt
);

    import laser_pkg::*;

    localparam int c_AW     = 2 * CW;
    localparam int c_PASS_W = (MAX_ITER > 1) ? $clog2(MAX_ITER) : 1;
    localparam int c_CNT_W  = $clog2(MAX_OUT + 1);

    state_t               r_state;
    logic [c_AW-1:0]      r_addr;
    logic [c_PASS_W-1:0]  r_pass;
    pos_t                 r_c1;
    pos_t                 r_c2;
    pos_t                 r_res1;
    pos_t                 r_res2;
    pos_t                 r_best_pos;
    logic [NW-1:0]        r_best_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;

    pos_t                 w_cand;
    pos_t                 w_pop_pos;
    pos_t                 w_opt_prev;
    pos_t                 w_fixed;
    logic [c_CNT_W-1:0]   w_cnt;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_req_valid;
    logic                 w_accept;
    logic                 w_pop;
    logic                 w_spurious;
    logic                 w_start;
    logic                 w_drained;
    logic                 w_converged;
    logic                 w_last_pass;
    logic                 w_finish;
    logic                 w_pass_init;

    assign w_cand      = pos_t'(r_addr);
    assign w_req_valid = (r_state == SWEEP) & ~w_full;
    assign w_accept    = w_req_valid & ev_req_ready;
    assign w_pop       = ev_rsp_valid & ~w_empty;
    assign w_spurious  = ev_rsp_valid & w_empty;
    assign w_start     = (r_state == IDLE) & start;
    // The pass is fully absorbed once the final outstanding response pops this cycle.
    assign w_drained   = (w_cnt == '0) | ((w_cnt == c_CNT_W'(1)) & w_pop);
    // Odd passes move C2 with C1 held; even passes the reverse.
    assign w_opt_prev  = r_pass[0] ? r_c2 : r_c1;
    assign w_fixed     = r_pass[0] ? r_c1 : r_c2;
    assign w_converged = (r_pass != '0) & (r_best_pos == w_opt_prev);
    assign w_last_pass = (r_pass == c_PASS_W'(MAX_ITER - 1));
    assign w_finish    = w_converged | w_last_pass;
    assign w_pass_init = w_start | ((r_state == SWAP) & ~w_finish);

    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;
    assign C1X          = r_res1.x;
    assign C1Y          = r_res1.y;
    assign C2X          = r_res2.x;
    assign C2Y          = r_res2.y;
    assign ev_req_valid = w_req_valid;
    assign ev_cx        = w_cand.x;
    assign ev_cy        = w_cand.y;
    assign ev_fx        = w_fixed.x;
    assign ev_fy        = w_fixed.y;

    laser_cand_fifo #(
        .DEPTH   (MAX_OUT)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .i_push  (w_accept),
        .i_din   (w_cand),
        .i_pop   (w_pop),
        .o_dout  (w_pop_pos),
        .o_count (w_cnt),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Best candidate of the current pass; the later candidate wins equal counts.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_best_cnt <= '0;
            r_best_pos <= '0;
        end else if (w_pass_init) begin
            r_best_cnt <= '0;
            r_best_pos <= '0;
        end else if (w_pop && (ev_rsp_cnt >= r_best_cnt)) begin
            r_best_cnt <= ev_rsp_cnt;
            r_best_pos <= w_pop_pos;
        end
    end

    // Sticky error for a response arriving with nothing outstanding; a new search clears it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_err <= 1'b0;
        end else if (w_start) begin
            r_err <= 1'b0;
        end else if (w_spurious) begin
            r_err <= 1'b1;
        end
    end

    // Search sequencer: grid addressing, pass alternation and result hand-off.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_pass  <= '0;
            r_c1    <= '0;
            r_c2    <= '0;
            r_res1  <= '0;
            r_res2  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= SWEEP;
                        r_busy  <= 1'b1;
                        r_addr  <= '0;
                        r_pass  <= '0;
                        r_c1    <= '0;
                        r_c2    <= '0;
                    end
                end
                SWEEP: begin
                    if (w_accept) begin
                        // The address parks at the last cell rather than wrapping into the next pass.
                        if (&r_addr) r_state <= DRAIN;
                        else         r_addr  <= r_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    if (w_drained) r_state <= SWAP;
                end
                SWAP: begin
                    if (r_pass[0]) r_c2 <= r_best_pos;
                    else           r_c1 <= r_best_pos;
                    if (w_finish) begin
                        r_state <= FINISH;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_res1  <= r_pass[0] ? r_c1 : r_best_pos;
                        r_res2  <= r_pass[0] ? r_best_pos : r_c2;
                    end else begin
                        r_state <= SWEEP;
                        r_pass  <= r_pass + 1'b1;
                        r_addr  <= '0;
                    end
                end
                FINISH: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_laser_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_laser_scan_ctrl
//  Purpose  : Self-checking bench for laser_scan_ctrl with an evaluator stub
//             and an algorithm-level model of the alternating search.
//  Revision : 1.0  initial release
// ============================================================================
module tb_laser_scan_ctrl;

    localparam int MAX_ITER = 6;
    localparam int MAX_OUT  = 4;
    localparam int LIMIT    = 20000;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       start = 1'b0;
    logic       ev_req_ready = 1'b0;
    logic       ev_rsp_valid = 1'b0;
    logic [5:0] ev_rsp_cnt = '0;
    logic       busy, done, err, ev_req_valid;
    logic [3:0] C1X, C1Y, C2X, C2Y, ev_cx, ev_cy, ev_fx, ev_fy;

    laser_scan_ctrl dut (
        .CLK          (CLK),
        .RST          (RST),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .C1X          (C1X),
        .C1Y          (C1Y),
        .C2X          (C2X),
        .C2Y          (C2Y),
        .err          (err),
        .ev_req_valid (ev_req_valid),
        .ev_req_ready (ev_req_ready),
        .ev_cx        (ev_cx),
        .ev_cy        (ev_cy),
        .ev_fx        (ev_fx),
        .ev_fy        (ev_fy),
        .ev_rsp_valid (ev_rsp_valid),
        .ev_rsp_cnt   (ev_rsp_cnt)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Evaluator stub: mode 0 converging peaks, mode 1 all zero, mode 2 peak moves each pass.
    function automatic int stub(input int mode, input int cx, input int cy,
                                input int fx, input int fy, input int p);
        if (mode == 1) return 0;
        if (cx == fx && cy == fy) return 0;
        if (mode == 0) begin
            if (cx == 5 && cy == 7)  return 9;
            if (cx == 10 && cy == 2) return 8;
            return 0;
        end
        if (cx == p + 1 && cy == 0) return 5;
        return 0;
    endfunction

    // Algorithm-level model: per pass, argmax over the grid with later-wins ties.
    int exp_fx [MAX_ITER];
    int exp_fy [MAX_ITER];
    int exp_passes, m_c1x, m_c1y, m_c2x, m_c2y;

    task automatic run_model(input int mode);
        int fx, fy, bc, bx, by, v, px, py;
        m_c1x = 0; m_c1y = 0; m_c2x = 0; m_c2y = 0; exp_passes = 0;
        for (int p = 0; p < MAX_ITER; p++) begin
            fx = (p % 2 == 1) ? m_c1x : m_c2x;
            fy = (p % 2 == 1) ? m_c1y : m_c2y;
            exp_fx[p] = fx; exp_fy[p] = fy;
            bc = 0; bx = 0; by = 0;
            for (int i = 0; i < 256; i++) begin
                v = stub(mode, i % 16, i / 16, fx, fy, p);
                if (v >= bc) begin bc = v; bx = i % 16; by = i / 16; end
            end
            if (p % 2 == 0) begin px = m_c1x; py = m_c1y; m_c1x = bx; m_c1y = by; end
            else            begin px = m_c2x; py = m_c2y; m_c2x = bx; m_c2y = by; end
            exp_passes = p + 1;
            if ((p >= 1 && bx == px && by == py) || p == MAX_ITER - 1) break;
        end
    endtask

    typedef struct { int due; int cnt; } rsp_t;
    rsp_t q[$];
    int  cyc = 0, acc = 0, rsp_n = 0, done_cycles = 0, last_due = 0;
    int  cur_mode = 0, lat_max = 1, prev_cx = 0, prev_cy = 0;
    bit  rand_ready = 0, run_active = 0, spur_req = 0, prev_stall = 0;

    // Evaluator stub plus per-cycle compare against the model.
    initial begin
        rsp_t r;
        int   lat;
        forever begin
            @(negedge CLK);
            cyc++;
            ev_rsp_valid = 1'b0;
            ev_rsp_cnt   = '0;
            if (RST) begin
                q.delete();
                ev_req_ready = 1'b0;
                prev_stall = 0;
                last_due = 0;
                continue;
            end
            if (done) done_cycles++;
            if (run_active) begin
                chk("outstanding_max", ((acc - rsp_n) <= MAX_OUT) ? 1 : 0, 1);
                if (prev_stall) begin
                    chk("stall_cx", ev_cx, prev_cx);
                    chk("stall_cy", ev_cy, prev_cy);
                end
                if (ev_req_valid) begin
                    chk("valid_busy", busy, 1);
                    chk("cand_x", ev_cx, acc % 16);
                    chk("cand_y", ev_cy, (acc % 256) / 16);
                    if (acc / 256 < MAX_ITER) begin
                        chk("fixed_x", ev_fx, exp_fx[acc / 256]);
                        chk("fixed_y", ev_fy, exp_fy[acc / 256]);
                    end
                end
            end
            if (spur_req) begin
                ev_rsp_valid = 1'b1;
                spur_req = 0;
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                ev_rsp_valid = 1'b1;
                ev_rsp_cnt   = 6'(q[0].cnt);
                void'(q.pop_front());
                rsp_n++;
            end
            ev_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ev_req_valid && ev_req_ready) begin
                lat   = $urandom_range(1, lat_max);
                r.due = cyc + lat;
                if (r.due <= last_due) r.due = last_due + 1;
                last_due = r.due;
                r.cnt = stub(cur_mode, ev_cx, ev_cy, ev_fx, ev_fy, acc / 256);
                q.push_back(r);
                acc++;
            end
            prev_stall = ev_req_valid && !ev_req_ready;
            prev_cx = ev_cx;
            prev_cy = ev_cy;
        end
    end

    task automatic begin_search(input int mode, input bit rnd, input int lmax);
        run_model(mode);
        @(negedge CLK);
        cur_mode = mode; rand_ready = rnd; lat_max = lmax;
        acc = 0; rsp_n = 0; done_cycles = 0; last_due = 0;
        run_active = 1;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        chk("busy_rise", busy, 1);
        chk("err_clear", err, 0);
    endtask

    task automatic run_search(input string tag, input int mode, input bit rnd, input int lmax,
                              input int exp_cyc, input int l1x, input int l1y,
                              input int l2x, input int l2y, input int lpass);
        int k;
        begin_search(mode, rnd, lmax);
        k = 1;
        while (!done && k < LIMIT) begin
            @(negedge CLK);
            k++;
        end
        if (!done) begin
            chk({tag, "_timeout"}, 0, 1);
        end else begin
            if (exp_cyc >= 0) chk({tag, "_done_cycle"}, k, exp_cyc);
            chk({tag, "_busy_at_done"}, busy, 0);
            chk({tag, "_c1x_model"}, C1X, m_c1x);
            chk({tag, "_c1y_model"}, C1Y, m_c1y);
            chk({tag, "_c2x_model"}, C2X, m_c2x);
            chk({tag, "_c2y_model"}, C2Y, m_c2y);
            chk({tag, "_accepts_model"}, acc, 256 * exp_passes);
            chk({tag, "_c1x"}, C1X, l1x);
            chk({tag, "_c1y"}, C1Y, l1y);
            chk({tag, "_c2x"}, C2X, l2x);
            chk({tag, "_c2y"}, C2Y, l2y);
            chk({tag, "_accepts"}, acc, 256 * lpass);
            chk({tag, "_err"}, err, 0);
        end
        repeat (3) @(negedge CLK);
        chk({tag, "_done_once"}, done_cycles, 1);
        chk({tag, "_done_low"}, done, 0);
        chk({tag, "_held_c1x"}, C1X, l1x);
        run_active = 0;
    endtask

    initial begin
        int k;
        repeat (3) @(negedge CLK);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_valid", ev_req_valid, 0);
        chk("rst_coords", {C1X, C1Y, C2X, C2Y, ev_cx, ev_cy, ev_fx, ev_fy}, 0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        // Converging stub, ready high, single-cycle latency: 3 passes of 258 cycles.
        run_search("conv", 0, 1'b0, 1, 775, 5, 7, 10, 2, 3);
        // All-zero counts: later candidates win ties.
        run_search("zero", 1, 1'b0, 1, 775, 15, 15, 15, 15, 3);
        // Random backpressure and 1-5 cycle latency.
        run_search("bp", 0, 1'b1, 5, -1, 5, 7, 10, 2, 3);
        // Peak moves every pass: runs to the pass limit.
        run_search("move", 2, 1'b0, 3, -1, 5, 0, 6, 0, 6);

        // Spurious response while idle sets a sticky error; the next start clears it.
        @(negedge CLK);
        spur_req = 1;
        k = 0;
        while (!err && k < 5) begin @(negedge CLK); k++; end
        chk("spur_err_set", err, 1);
        repeat (3) @(negedge CLK);
        chk("spur_err_held", err, 1);
        run_search("after_err", 0, 1'b0, 1, 775, 5, 7, 10, 2, 3);

        // Asynchronous reset in the middle of a search.
        begin_search(0, 1'b0, 1);
        k = 0;
        while (acc < 100 && k < 2000) begin @(negedge CLK); k++; end
        chk("rst100_reached", acc, 100);
        @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_valid", ev_req_valid, 0);
        chk("arst_done", done, 0);
        chk("arst_coords", {C1X, C1Y, C2X, C2Y, ev_cx, ev_cy, ev_fx, ev_fy}, 0);
        run_active = 0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        done_cycles = 0;
        repeat (600) @(negedge CLK);
        chk("arst_no_done", done_cycles, 0);
        chk("arst_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
